int_check: RTL and testbench
============================

Name: int_check

Overview:
- Byte-serial lexical checker for C-style integer declaration statements, e.g. "int a, b_1;".
- Consumes one ASCII character per clock.
- Raises out for one cycle when the statement just terminated by ';' is a valid declaration.
- Sits behind a character-stream source; statements follow one another back to back.

Parameters:
- None. Character codes are fixed ASCII.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears the FSM immediately.
- in  input  8  ASCII character, sampled every rising edge (no valid strobe).
- out  output  1  high while the most recently sampled ';' completed a valid declaration.

Behaviour:
Character classes:
- WS: space 0x20; tab 0x09 only with the optional feature.
- LETTER: a-z, A-Z.
- DIGIT: 0-9.
- UND: '_'.
- Any other byte (including ',' and ';' outside allowed positions) is illegal where not expected.

Grammar (one statement):
- WS* "int" WS+ ID WS* ( ',' WS* ID WS* )* ';'
- ID = (LETTER|UND)(LETTER|DIGIT|UND)*.
- Keyword is lowercase only.
- An ID exactly equal to "int" is invalid. Track the first three ID characters, e.g. with a keyword-match sub-state.

FSM states:
- START: leading WS stays here. 'i' -> K_I. ';' -> START with no accept. Else -> ERR.
- K_I: 'n' -> K_N; else ERR.
- K_N: 't' -> K_T; else ERR.
- K_T: WS -> PRE_ID; else ERR. This rejects "inta", "int;" and "int,".
- PRE_ID (expecting ID): WS stays. LETTER/UND -> IN_ID. DIGIT, ',', ';' or other -> ERR.
- IN_ID:
  - LETTER/DIGIT/UND stays.
  - WS -> POST_ID.
  - ',' -> PRE_ID.
  - ';' -> ACCEPT.
  - Other -> ERR.
  - Any transition out of IN_ID whose completed ID equals "int" goes to ERR (or to START on ';') instead.
- POST_ID: WS stays. ',' -> PRE_ID. ';' -> ACCEPT. Else -> ERR.
- ACCEPT: out=1. The next character is processed exactly as in START.
- ERR: out=0; all characters except ';' are ignored. ';' -> START.

Output and reset:
- out = (state == ACCEPT). Moore output, no combinational path from in.
- out rises in the cycle after the edge that samples the terminating ';' and lasts exactly one cycle unless the next character is another complete statement end (impossible; minimum statement is 6 chars).
- Reset: state = START, out = 0, keyword tracker cleared.
- Reset asserted mid-statement discards the partial statement. The first character after release is treated as the start of a new statement.
- No length limit on IDs or on the number of declarators. NUL bytes (0x00) are illegal characters.

Optional Feature:
- Macro INTCHECK_TAB_WS_EN.
- Defined: tab (0x09) is accepted as WS everywhere WS is allowed.
- Undefined: only 0x20 is WS; tab is illegal and drives the FSM to ERR (or is ignored while already in ERR).

Test Plan:
- Reset, then "int 711;" -> out stays 0 every cycle: ID starts with a digit, ERR then back to START on ';'.
- "int a;" -> out=1 for exactly the one cycle after the ';' edge, 0 otherwise.
- "  int a_1 , _B9,c ;" -> out=1 one cycle after ';'. Next "int x;" -> out pulses again after its ';'.
- "int int;" -> out=0. Then "inta;" -> out=0. Then "int x;" -> out=1 (error recovery across statements).
- "int x," followed by a reset pulse mid-cycle -> out=0 immediately; "int y;" after release -> out=1 after ';'.
- "int\ta;" -> out=1 with INTCHECK_TAB_WS_EN defined, out=0 without it.

Source files
------------

// File: rtl/int_check.sv
// rtl/int_check.sv - byte-serial checker for C "int a, b;" declarations
// Optional: define INTCHECK_TAB_WS_EN to treat tab (0x09) as whitespace.
module int_check (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in,
    output logic       out
);

    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_I     = 8'h69;
    localparam logic [7:0] CH_N     = 8'h6e;
    localparam logic [7:0] CH_T     = 8'h74;
    localparam logic [7:0] CH_UND   = 8'h5f;
    localparam logic [7:0] CH_COMMA = 8'h2c;
    localparam logic [7:0] CH_SEMI  = 8'h3b;

    typedef enum logic [3:0] {
        S_START, S_K_I, S_K_N, S_K_T, S_PRE_ID,
        S_IN_ID, S_POST_ID, S_ACCEPT, S_ERR
    } state_t;

    // Progress of the current ID towards the reserved word "int".
    typedef enum logic [1:0] {KW_NONE, KW_I, KW_IN, KW_INT} kw_t;

    state_t state, state_next;
    kw_t    kw, kw_next;

    logic is_ws, is_letter, is_digit, is_und, is_head, is_idc;

    always_comb begin
`ifdef INTCHECK_TAB_WS_EN
        is_ws = (in == CH_SP) || (in == CH_TAB);
`else
        is_ws = (in == CH_SP);
`endif
        is_letter = ((in >= 8'h61) && (in <= 8'h7a)) || ((in >= 8'h41) && (in <= 8'h5a));
        is_digit  = (in >= 8'h30) && (in <= 8'h39);
        is_und    = (in == CH_UND);
        is_head   = is_letter || is_und;
        is_idc    = is_head || is_digit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_START;
            kw    <= KW_NONE;
        end else begin
            state <= state_next;
            kw    <= kw_next;
        end
    end

    always_comb begin
        state_next = state;
        kw_next    = kw;
        case (state)
            S_START, S_ACCEPT: begin
                if (is_ws || in == CH_SEMI) state_next = S_START;
                else if (in == CH_I)        state_next = S_K_I;
                else                        state_next = S_ERR;
            end
            S_K_I: state_next = (in == CH_N) ? S_K_N : S_ERR;
            S_K_N: state_next = (in == CH_T) ? S_K_T : S_ERR;
            S_K_T: state_next = is_ws ? S_PRE_ID : S_ERR;
            S_PRE_ID: begin
                if (is_ws) begin
                    state_next = S_PRE_ID;
                end else if (is_head) begin
                    state_next = S_IN_ID;
                    kw_next    = (in == CH_I) ? KW_I : KW_NONE;
                end else begin
                    state_next = S_ERR;
                end
            end
            S_IN_ID: begin
                if (is_idc) begin
                    state_next = S_IN_ID;
                    case (kw)
                        KW_I:    kw_next = (in == CH_N) ? KW_IN  : KW_NONE;
                        KW_IN:   kw_next = (in == CH_T) ? KW_INT : KW_NONE;
                        default: kw_next = KW_NONE;
                    endcase
                end else if (is_ws) begin
                    state_next = (kw == KW_INT) ? S_ERR : S_POST_ID;
                end else if (in == CH_COMMA) begin
                    state_next = (kw == KW_INT) ? S_ERR : S_PRE_ID;
                end else if (in == CH_SEMI) begin
                    state_next = (kw == KW_INT) ? S_START : S_ACCEPT;
                end else begin
                    state_next = S_ERR;
                end
            end
            S_POST_ID: begin
                if (is_ws)                  state_next = S_POST_ID;
                else if (in == CH_COMMA)    state_next = S_PRE_ID;
                else if (in == CH_SEMI)     state_next = S_ACCEPT;
                else                        state_next = S_ERR;
            end
            S_ERR:   state_next = (in == CH_SEMI) ? S_START : S_ERR;
            default: state_next = S_START;
        endcase
    end

    always_comb begin
        out = (state == S_ACCEPT);
    end

endmodule

// File: tb/tb_int_check.sv
// tb/tb_int_check.sv - scoreboard bench for int_check with a string-level reference parser
module tb_int_check;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ch = 8'h20;
    logic       out;

    int checks = 0;
    int errors = 0;

    bit           exp_q[$];
    byte unsigned seg[$];
    byte unsigned gq[$];

    int_check dut (.clk(clk), .reset(reset), .in(ch), .out(out));

    always #5 clk = ~clk;

    function automatic bit is_ws(byte unsigned c);
`ifdef INTCHECK_TAB_WS_EN
        return (c == 8'h20) || (c == 8'h09);
`else
        return (c == 8'h20);
`endif
    endfunction

    function automatic bit is_head(byte unsigned c);
        return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z") || (c == "_");
    endfunction

    function automatic bit is_idc(byte unsigned c);
        return is_head(c) || (c >= "0" && c <= "9");
    endfunction

    function automatic bit piece_ok(byte unsigned p[$]);
        while (p.size() > 0 && is_ws(p[0])) void'(p.pop_front());
        while (p.size() > 0 && is_ws(p[p.size()-1])) void'(p.pop_back());
        if (p.size() == 0) return 1'b0;
        if (!is_head(p[0])) return 1'b0;
        for (int k = 1; k < p.size(); k++)
            if (!is_idc(p[k])) return 1'b0;
        if (p.size() == 3 && p[0] == "i" && p[1] == "n" && p[2] == "t") return 1'b0;
        return 1'b1;
    endfunction

    // Statement text before ';' -> is it a valid declaration?
    function automatic bit stmt_ok(byte unsigned s[$]);
        int n = s.size();
        int i = 0;
        byte unsigned piece[$];
        while (i < n && is_ws(s[i])) i++;
        if (n - i < 4) return 1'b0;
        if (s[i] != "i" || s[i+1] != "n" || s[i+2] != "t" || !is_ws(s[i+3])) return 1'b0;
        for (int j = i + 4; j < n; j++) begin
            if (s[j] == ",") begin
                if (!piece_ok(piece)) return 1'b0;
                piece.delete();
            end else begin
                piece.push_back(s[j]);
            end
        end
        return piece_ok(piece);
    endfunction

    task automatic send_char(byte unsigned c);
        @(negedge clk);
        reset = 1'b0;
        ch = c;
        if (c == ";") begin
            exp_q.push_back(stmt_ok(seg));
            seg.delete();
        end else begin
            seg.push_back(c);
            exp_q.push_back(1'b0);
        end
    endtask

    task automatic send_str(string s);
        for (int k = 0; k < s.len(); k++) send_char(s[k]);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset = 1'b1;
        ch = 8'($urandom);
        exp_q.push_back(1'b0);
        seg.delete();
    endtask

    // Reset asserted mid-cycle while out is high must clear it at once.
    task automatic async_reset_check();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset out=%b expected 0", out);
        end
        @(negedge clk);
        ch = 8'h20;
        exp_q.push_back(1'b0);
        seg.delete();
    endtask

    task automatic gen_push(string s);
        for (int k = 0; k < s.len(); k++) gq.push_back(s[k]);
    endtask

    task automatic gen_ws(int lo, int hi);
        repeat ($urandom_range(hi, lo)) gq.push_back(($urandom_range(3, 0) == 0) ? 8'h09 : 8'h20);
    endtask

    task automatic gen_id();
        string heads = "abcdefghijklmnopqrstuvwxyzABCDEFGHIJKLMNOPQRSTUVWXYZ_";
        string tails = "abcxyzQZ_0123456789int";
        case ($urandom_range(9, 0))
            0: gen_push("int");
            1: gen_push("9ab");
            2: ;
            3: gen_push("intx");
            4: gen_push("in");
            default: begin
                gq.push_back(heads[$urandom_range(heads.len()-1, 0)]);
                repeat ($urandom_range(5, 0)) gq.push_back(tails[$urandom_range(tails.len()-1, 0)]);
            end
        endcase
    endtask

    task automatic gen_stmt();
        int nd;
        gq.delete();
        gen_ws(0, 2);
        case ($urandom_range(9, 0))
            0: gen_push("Int");
            1: gen_push("in");
            2: gen_push("inta");
            default: gen_push("int");
        endcase
        gen_ws(0, 2);
        nd = $urandom_range(3, 1);
        for (int d = 0; d < nd; d++) begin
            gen_id();
            gen_ws(0, 1);
            if (d != nd - 1) begin
                gq.push_back(",");
                gen_ws(0, 1);
            end
        end
        if ($urandom_range(7, 0) == 0 && gq.size() > 0)
            gq[$urandom_range(gq.size()-1, 0)] = 8'($urandom_range(127, 0));
        gq.push_back(";");
    endtask

    initial begin : monitor
        bit e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (out !== e) begin
                    errors++;
                    $display("FAIL out_seq t=%0t out=%b expected %b", $time, out, e);
                end
            end
        end
    end

    initial begin : driver
        int budget;
        repeat (3) @(negedge clk);
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("FAIL reset_state out=%b expected 0", out);
        end

        send_str("int 711;");
        send_str("int a;");
        send_str("  int a_1 , _B9,c ;");
        send_str("int x;");
        send_str("int int;");
        send_str("inta;");
        send_str("int x;");
        send_str("int x,");
        reset_pulse();
        send_str("int y;");
        async_reset_check();
        send_str("int\ta;");
        send_str("int;int,;; int _;");
        send_char(8'h00);
        send_str("int q;");
        send_str("int intx, in, i;");

        for (int s = 0; s < 80; s++) begin
            gen_stmt();
            foreach (gq[k]) send_char(gq[k]);
            if ($urandom_range(15, 0) == 0) reset_pulse();
        end

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
